// File: rtl/reg_write_arbiter_if.sv
// Register-file write-side bus: ALU writeback, multi-cycle results,
// issue tracking, decode operand probes and the register file write port.
//
// Ports (signals carried):
//   wb_valid/wb_reg/wb_data, wb_stall   ALU writeback
//   mc_valid/mc_reg/mc_data, mc_ready   multi-cycle result stream
//   iss_valid/iss_reg                   multi-cycle issue
//   read_reg_1/2, busy_1/2              decode operand probes
//   RegWrite/write_reg/write_data       register file write port
//   fifo_count                          result FIFO occupancy
//   fwd_hit_1/2, fwd_data_1/2           bypass (REG_WRITE_ARBITER_FWD_EN)
interface reg_write_arbiter_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          wb_valid;
  logic [4:0]    wb_reg;
  logic [31:0]   wb_data;
  logic          wb_stall;

  logic          mc_valid;
  logic          mc_ready;
  logic [4:0]    mc_reg;
  logic [31:0]   mc_data;

  logic          iss_valid;
  logic [4:0]    iss_reg;

  logic [4:0]    read_reg_1;
  logic [4:0]    read_reg_2;
  logic          busy_1;
  logic          busy_2;

  logic          RegWrite;
  logic [4:0]    write_reg;
  logic [31:0]   write_data;
  logic [CW-1:0] fifo_count;

`ifdef REG_WRITE_ARBITER_FWD_EN
  logic          fwd_hit_1;
  logic          fwd_hit_2;
  logic [31:0]   fwd_data_1;
  logic [31:0]   fwd_data_2;
`endif

  modport master (
    input  wb_valid, wb_reg, wb_data,
    output wb_stall,
    input  mc_valid, mc_reg, mc_data,
    output mc_ready,
    input  iss_valid, iss_reg,
    input  read_reg_1, read_reg_2,
    output busy_1, busy_2,
    output RegWrite, write_reg, write_data,
`ifdef REG_WRITE_ARBITER_FWD_EN
    output fwd_hit_1, fwd_hit_2,
    output fwd_data_1, fwd_data_2,
`endif
    output fifo_count
  );

  modport slave (
    output wb_valid, wb_reg, wb_data,
    input  wb_stall,
    output mc_valid, mc_reg, mc_data,
    input  mc_ready,
    output iss_valid, iss_reg,
    output read_reg_1, read_reg_2,
    input  busy_1, busy_2,
    input  RegWrite, write_reg, write_data,
`ifdef REG_WRITE_ARBITER_FWD_EN
    input  fwd_hit_1, fwd_hit_2,
    input  fwd_data_1, fwd_data_2,
`endif
    input  fifo_count
  );

endinterface

// File: rtl/reg_write_arbiter.sv
// Register file write arbiter: merges the ALU writeback with a buffered
// multi-cycle result stream, with starvation guard and pending scoreboard.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  reg_write_arbiter_if.master (all handshake/data signals)
// Parameters: DEPTH (FIFO entries, power of 2, >=2), STARVE_MAX.
// Optional macro REG_WRITE_ARBITER_FWD_EN adds decode bypass outputs.
module reg_write_arbiter #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  reg_write_arbiter_if.master bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [4:0]    rmem_q [DEPTH];
  logic [31:0]   dmem_q [DEPTH];

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full_q, full_d;

  logic [SW-1:0] stv_q, stv_d;
  logic          stall_q, stall_d;

  logic [31:0]   pend_q, pend_d;

  logic          we_q, we_d;
  logic [4:0]    wr_q, wr_d;
  logic [31:0]   wd_q, wd_d;

  logic          empty;
  logic          alu_win;
  logic          pop;
  logic          push;
  logic          store;
  logic [4:0]    head_reg;
  logic [31:0]   head_data;

  assign empty     = (cnt_q == '0);
  assign head_reg  = rmem_q[rptr_q];
  assign head_data = dmem_q[rptr_q];

  // A write to x0 is accepted but never competes with the FIFO.
  assign alu_win = bus.wb_valid
                 && !stall_q
                 && (bus.wb_reg != 5'd0);
  assign pop     = !alu_win && !empty;
  assign push    = bus.mc_valid && !full_q;
  // x0 results complete the handshake but are dropped.
  assign store   = push && (bus.mc_reg != 5'd0);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (store) wptr_d = wptr_q + AW'(1);
    if (pop)   rptr_d = rptr_q + AW'(1);
    cnt_d  = cnt_q + CW'(store) - CW'(pop);
    full_d = (cnt_d == CW'(DEPTH));
  end

  // Starvation: count ALU wins over a waiting head; the cycle the count
  // hits the limit, stall the ALU for one cycle so the head drains.
  always_comb begin
    stv_d = stv_q;
    if (pop)
      stv_d = '0;
    else if (alu_win && !empty)
      stv_d = stv_q + SW'(1);
    stall_d = (stv_d == SW'(STARVE_MAX));
  end

  always_comb begin
    we_d = alu_win || pop;
    wr_d = wr_q;
    wd_d = wd_q;
    unique case (1'b1)
      alu_win: begin
        wr_d = bus.wb_reg;
        wd_d = bus.wb_data;
      end
      pop: begin
        wr_d = head_reg;
        wd_d = head_data;
      end
      default: ;
    endcase
  end

  // Clear before set so a re-issue on the popping register stays busy.
  // ALU writes leave pending bits alone: the later result still lands.
  always_comb begin
    pend_d = pend_q;
    if (pop)
      pend_d[head_reg] = 1'b0;
    if (bus.iss_valid)
      pend_d[bus.iss_reg] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (store) begin
      rmem_q[wptr_q] <= bus.mc_reg;
      dmem_q[wptr_q] <= bus.mc_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      stv_q   <= '0;
      stall_q <= 1'b0;
      pend_q  <= '0;
      we_q    <= 1'b0;
      wr_q    <= '0;
      wd_q    <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      stv_q   <= stv_d;
      stall_q <= stall_d;
      pend_q  <= pend_d;
      we_q    <= we_d;
      wr_q    <= wr_d;
      wd_q    <= wd_d;
    end
  end

  assign bus.wb_stall   = stall_q;
  assign bus.mc_ready   = !full_q;
  assign bus.fifo_count = cnt_q;
  assign bus.RegWrite   = we_q;
  assign bus.write_reg  = wr_q;
  assign bus.write_data = wd_q;

`ifdef REG_WRITE_ARBITER_FWD_EN
  logic land_1;
  logic land_2;

  // The head landing this edge no longer needs decode to wait.
  assign land_1 = pop && (head_reg == bus.read_reg_1);
  assign land_2 = pop && (head_reg == bus.read_reg_2);

  assign bus.busy_1 = pend_q[bus.read_reg_1] && !land_1;
  assign bus.busy_2 = pend_q[bus.read_reg_2] && !land_2;

  assign bus.fwd_hit_1 = we_q
                      && (wr_q == bus.read_reg_1)
                      && (bus.read_reg_1 != 5'd0);
  assign bus.fwd_hit_2 = we_q
                      && (wr_q == bus.read_reg_2)
                      && (bus.read_reg_2 != 5'd0);
  assign bus.fwd_data_1 = wd_q;
  assign bus.fwd_data_2 = wd_q;
`else
  assign bus.busy_1 = pend_q[bus.read_reg_1];
  assign bus.busy_2 = pend_q[bus.read_reg_2];
`endif

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed self-checking bench for reg_write_arbiter
// (DEPTH=4, STARVE_MAX=8).
module tb_reg_write_arbiter;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  reg_write_arbiter_if #(.DEPTH(4)) bus ();

  reg_write_arbiter #(
    .DEPTH(4),
    .STARVE_MAX(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.wb_valid   = 1'b0;
    bus.wb_reg     = '0;
    bus.wb_data    = '0;
    bus.mc_valid   = 1'b0;
    bus.mc_reg     = '0;
    bus.mc_data    = '0;
    bus.iss_valid  = 1'b0;
    bus.iss_reg    = '0;
    bus.read_reg_1 = '0;
    bus.read_reg_2 = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // reset state
    chk("rst_we",    32'(bus.RegWrite),   32'h0);
    chk("rst_wreg",  32'(bus.write_reg),  32'h0);
    chk("rst_wdata", bus.write_data,      32'h0);
    chk("rst_stall", 32'(bus.wb_stall),   32'h0);
    chk("rst_cnt",   32'(bus.fifo_count), 32'h0);
    chk("rst_rdy",   32'(bus.mc_ready),   32'h1);

    // ALU only
    bus.wb_valid = 1'b1;
    bus.wb_reg   = 5'd5;
    bus.wb_data  = 32'hDEADBEEF;
    tick();
    chk("alu_we",    32'(bus.RegWrite),  32'h1);
    chk("alu_wreg",  32'(bus.write_reg), 32'h5);
    chk("alu_wdata", bus.write_data,     32'hDEADBEEF);
    bus.wb_reg  = 5'd0;
    bus.wb_data = 32'h1;
    tick();
    chk("alu0_we",    32'(bus.RegWrite),  32'h0);
    chk("alu0_wreg",  32'(bus.write_reg), 32'h5);
    chk("alu0_wdata", bus.write_data,     32'hDEADBEEF);
    bus.wb_valid = 1'b0;

    // scoreboard
    bus.iss_valid  = 1'b1;
    bus.iss_reg    = 5'd9;
    bus.read_reg_1 = 5'd9;
    bus.read_reg_2 = 5'd0;
    tick();
    bus.iss_valid = 1'b0;
    chk("sb_busy1", 32'(bus.busy_1), 32'h1);
    chk("sb_busy2_x0", 32'(bus.busy_2), 32'h0);
    bus.mc_valid = 1'b1;
    bus.mc_reg   = 5'd9;
    bus.mc_data  = 32'h99;
    tick();
    bus.mc_valid = 1'b0;
    chk("sb_cnt1", 32'(bus.fifo_count), 32'h1);
`ifdef REG_WRITE_ARBITER_FWD_EN
    chk("sb_busy_prepop", 32'(bus.busy_1), 32'h0);
`else
    chk("sb_busy_prepop", 32'(bus.busy_1), 32'h1);
`endif
    tick();
    chk("sb_pop_we",    32'(bus.RegWrite),  32'h1);
    chk("sb_pop_wreg",  32'(bus.write_reg), 32'h9);
    chk("sb_pop_wdata", bus.write_data,     32'h99);
    chk("sb_pop_busy",  32'(bus.busy_1),    32'h0);
    chk("sb_pop_cnt",   32'(bus.fifo_count), 32'h0);

    // re-issue in the same cycle as the pop
    bus.iss_valid = 1'b1;
    bus.iss_reg   = 5'd9;
    tick();
    bus.iss_valid = 1'b0;
    bus.mc_valid  = 1'b1;
    bus.mc_reg    = 5'd9;
    bus.mc_data   = 32'h98;
    tick();
    bus.mc_valid  = 1'b0;
    bus.iss_valid = 1'b1;
    tick();
    bus.iss_valid = 1'b0;
    chk("reiss_wdata", bus.write_data,  32'h98);
    chk("reiss_busy",  32'(bus.busy_1), 32'h1);
    bus.mc_valid = 1'b1;
    bus.mc_data  = 32'h97;
    tick();
    bus.mc_valid = 1'b0;
    tick();
    chk("reiss_clr_wdata", bus.write_data,  32'h97);
    chk("reiss_clr_busy",  32'(bus.busy_1), 32'h0);

    // priority: FIFO holds r7, ALU writes r3 the same cycle
    bus.mc_valid = 1'b1;
    bus.mc_reg   = 5'd7;
    bus.mc_data  = 32'h11;
    tick();
    bus.mc_valid = 1'b0;
    bus.wb_valid = 1'b1;
    bus.wb_reg   = 5'd3;
    bus.wb_data  = 32'h22;
    tick();
    bus.wb_valid = 1'b0;
    chk("pri_alu_wreg",  32'(bus.write_reg),  32'h3);
    chk("pri_alu_wdata", bus.write_data,      32'h22);
    chk("pri_alu_cnt",   32'(bus.fifo_count), 32'h1);
    tick();
    chk("pri_mc_we",    32'(bus.RegWrite),   32'h1);
    chk("pri_mc_wreg",  32'(bus.write_reg),  32'h7);
    chk("pri_mc_wdata", bus.write_data,      32'h11);
    chk("pri_mc_cnt",   32'(bus.fifo_count), 32'h0);

    // multi-cycle result to x0 is dropped
    bus.mc_valid = 1'b1;
    bus.mc_reg   = 5'd0;
    bus.mc_data  = 32'h55;
    tick();
    bus.mc_valid = 1'b0;
    chk("mc0_cnt", 32'(bus.fifo_count), 32'h0);
    tick();
    chk("mc0_we", 32'(bus.RegWrite), 32'h0);

    // starvation
    bus.mc_valid = 1'b1;
    bus.mc_reg   = 5'd12;
    bus.mc_data  = 32'hC0;
    tick();
    bus.mc_valid = 1'b0;
    chk("stv_cnt", 32'(bus.fifo_count), 32'h1);
    chk("stv_we0", 32'(bus.RegWrite),   32'h0);
    for (int k = 1; k <= 12; k++) begin
      bus.wb_valid = 1'b1;
      bus.wb_reg   = 5'd20;
      bus.wb_data  = (k <= 9) ? 32'(k) : 32'(k - 1);
      tick();
      chk($sformatf("stv%0d_we", k),
          32'(bus.RegWrite), 32'h1);
      chk($sformatf("stv%0d_stall", k),
          32'(bus.wb_stall), (k == 8) ? 32'h1 : 32'h0);
      if (k == 9) begin
        chk("stv9_wreg",  32'(bus.write_reg), 32'd12);
        chk("stv9_wdata", bus.write_data,     32'hC0);
      end else begin
        chk($sformatf("stv%0d_wreg", k),
            32'(bus.write_reg), 32'd20);
        chk($sformatf("stv%0d_wdata", k),
            bus.write_data,
            (k < 9) ? 32'(k) : 32'(k - 1));
      end
    end
    bus.wb_valid = 1'b0;
    tick();
    chk("stv_end_we",  32'(bus.RegWrite),   32'h0);
    chk("stv_end_cnt", 32'(bus.fifo_count), 32'h0);

    // full FIFO under a saturating ALU
    for (int i = 0; i < 4; i++) begin
      bus.wb_valid = 1'b1;
      bus.wb_reg   = 5'd21;
      bus.wb_data  = 32'h100 + 32'(i);
      bus.mc_valid = 1'b1;
      bus.mc_reg   = 5'(1 + i);
      bus.mc_data  = 32'hA1 + 32'(i);
      tick();
      chk($sformatf("full%0d_wreg", i),
          32'(bus.write_reg), 32'd21);
      chk($sformatf("full%0d_cnt", i),
          32'(bus.fifo_count), 32'(i + 1));
    end
    chk("full_rdy", 32'(bus.mc_ready), 32'h0);
    bus.mc_reg  = 5'd5;
    bus.mc_data = 32'hA5;
    tick();
    chk("full_blk_cnt",   32'(bus.fifo_count), 32'h4);
    chk("full_blk_rdy",   32'(bus.mc_ready),   32'h0);
    chk("full_blk_stall", 32'(bus.wb_stall),   32'h0);
    bus.wb_valid = 1'b0;
    tick();
    chk("drain1_wreg",  32'(bus.write_reg),  32'd1);
    chk("drain1_wdata", bus.write_data,      32'hA1);
    chk("drain1_cnt",   32'(bus.fifo_count), 32'h3);
    chk("drain1_rdy",   32'(bus.mc_ready),   32'h1);
    tick();
    bus.mc_valid = 1'b0;
    chk("drain2_wreg",  32'(bus.write_reg),  32'd2);
    chk("drain2_wdata", bus.write_data,      32'hA2);
    chk("drain2_cnt",   32'(bus.fifo_count), 32'h3);
    for (int i = 3; i <= 5; i++) begin
      tick();
      chk($sformatf("drain%0d_wreg", i),
          32'(bus.write_reg), 32'(i));
      chk($sformatf("drain%0d_wdata", i),
          bus.write_data, 32'hA0 + 32'(i));
      chk($sformatf("drain%0d_cnt", i),
          32'(bus.fifo_count), 32'(5 - i));
    end

    // asynchronous reset with entries in flight
    for (int i = 0; i < 3; i++) begin
      bus.wb_valid  = 1'b1;
      bus.wb_reg    = 5'd21;
      bus.mc_valid  = 1'b1;
      bus.mc_reg    = 5'(13 + i);
      bus.mc_data   = 32'hB0 + 32'(i);
      bus.iss_valid = 1'b1;
      bus.iss_reg   = 5'(13 + i);
      tick();
    end
    bus.mc_valid   = 1'b0;
    bus.iss_valid  = 1'b0;
    bus.read_reg_1 = 5'd13;
    #1;
    chk("prerst_cnt",  32'(bus.fifo_count), 32'h3);
    chk("prerst_busy", 32'(bus.busy_1),     32'h1);
    rst = 1'b1;
    #1;
    chk("arst_cnt",   32'(bus.fifo_count), 32'h0);
    chk("arst_rdy",   32'(bus.mc_ready),   32'h1);
    chk("arst_we",    32'(bus.RegWrite),   32'h0);
    chk("arst_wreg",  32'(bus.write_reg),  32'h0);
    chk("arst_wdata", bus.write_data,      32'h0);
    chk("arst_stall", 32'(bus.wb_stall),   32'h0);
    for (int i = 0; i < 32; i++) begin
      bus.read_reg_1 = 5'(i);
      #1;
      chk($sformatf("arst_busy_r%0d", i),
          32'(bus.busy_1), 32'h0);
    end
    bus.wb_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_we",  32'(bus.RegWrite),   32'h0);
    chk("post_rst_cnt", 32'(bus.fifo_count), 32'h0);
    tick();
    chk("post_rst_we2", 32'(bus.RegWrite), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Write-side master for the 32x32 register file. Merges two result sources onto the file's single write port (RegWrite, write_reg, write_data):
  - the single-cycle ALU writeback;
  - a buffered multi-cycle unit (mult/div) result stream.
- Keeps a per-register pending scoreboard so decode can stall on operands still owed by the multi-cycle unit.
- Sits between the execute/writeback stages and register_file.

Parameters:
- DEPTH, 4, multi-cycle result FIFO entries (power of 2, >=2).
- STARVE_MAX, 8, consecutive cycles the FIFO head may be blocked by ALU writebacks before it is forced through.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- wb_valid  input  1  ALU writeback request.
- wb_reg  input  5  ALU destination register.
- wb_data  input  32  ALU result.
- wb_stall  output  1  ALU writeback not accepted this cycle; pipeline holds wb_*.
- mc_valid  input  1  multi-cycle result valid.
- mc_ready  output  1  FIFO can accept (= !full).
- mc_reg  input  5  multi-cycle destination.
- mc_data  input  32  multi-cycle result.
- iss_valid  input  1  multi-cycle op issued this cycle.
- iss_reg  input  5  its destination register.
- read_reg_1  input  5  decode operand address 1.
- read_reg_2  input  5  decode operand address 2.
- busy_1  output  1  read_reg_1 has a pending multi-cycle result.
- busy_2  output  1  read_reg_2 has a pending multi-cycle result.
- RegWrite  output  1  to register_file.
- write_reg  output  5  to register_file.
- write_data  output  32  to register_file.
- fifo_count  output  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (async, any time, including mid-operation): RegWrite=0, write_reg=0, write_data=0, wb_stall=0, FIFO emptied (fifo_count=0, mc_ready=1), starve counter=0, all pending bits=0. In-flight entries are discarded.
- FIFO push: on mc_valid && mc_ready.
  - mc_reg==0: accepted (handshake completes) but not stored.
  - Push while full is impossible because mc_ready=0.
  - Simultaneous push and pop with FIFO full: not allowed. mc_ready depends only on the registered full state.
- Write selection each cycle. The output registers update at the edge, giving 1-cycle latency.
  1. wb_valid && !wb_stall && wb_reg!=0: write ALU result. FIFO is not popped.
  2. Otherwise, if FIFO not empty: pop head and write it.
  3. Otherwise: RegWrite<=0. write_reg and write_data hold their previous values.
  - wb_valid with wb_reg==0 counts as accepted (when !wb_stall) and does not block the FIFO.
- Starvation:
  - The counter increments in each cycle where the FIFO is non-empty and an ALU write wins; it clears on any FIFO pop.
  - When the counter reaches STARVE_MAX, wb_stall is registered high for exactly the next cycle. In that cycle the FIFO head pops, the counter clears, and wb_stall returns to 0.
  - STARVE_MAX=8: at most 8 ALU writes in a row while the FIFO is non-empty.
- Scoreboard: pending[31:0].
  - iss_valid && iss_reg!=0 sets pending[iss_reg].
  - A FIFO pop clears pending[head_reg] (at the same edge as RegWrite loads).
  - Set and clear on the same register in the same cycle: set wins.
  - ALU writes never clear pending bits (WAW: the later multi-cycle result still lands).
  - pending[0] is always 0.
- busy_1 = pending[read_reg_1] and busy_2 = pending[read_reg_2]. Both are combinational, so reg 0 always reads 0.
- fifo_count, mc_ready and wb_stall come directly from registers (no combinational path from inputs).

Optional Feature:
- Macro: REG_WRITE_ARBITER_FWD_EN.
- Defined:
  - Adds ports fwd_hit_1/fwd_hit_2 (output, 1) and fwd_data_1/fwd_data_2 (output, 32).
  - fwd_hit_x = RegWrite && write_reg==read_reg_x && read_reg_x!=0; fwd_data_x = write_data. This lets decode bypass the write landing this cycle.
  - busy_x is additionally suppressed when the FIFO head is popping to read_reg_x this cycle.
- Undefined: these ports are absent, and busy_x is pure pending[].

Test Plan:
- Reset mid-FIFO: push 3 entries, assert rst for 1 cycle -> fifo_count=0, mc_ready=1, RegWrite=0, busy_1=0 for all addresses.
- ALU only: wb_valid, wb_reg=5, wb_data=0xDEADBEEF -> next cycle RegWrite=1, write_reg=5, write_data=0xDEADBEEF. With wb_reg=0 -> RegWrite=0.
- Priority: FIFO holds reg 7 = 0x11 and ALU writes reg 3 = 0x22 in the same cycle -> reg 3 written first, reg 7 written the following cycle (ALU idle).
- Starvation: FIFO non-empty, wb_valid held high for 12 cycles -> 8 ALU writes, then wb_stall=1 for 1 cycle with the FIFO head written, then ALU writes resume.
- Scoreboard: iss reg 9, read_reg_1=9 -> busy_1=1. Push and pop a result for reg 9 -> busy_1=0 the cycle after the pop. Re-issue reg 9 in the same cycle as the pop -> busy_1 stays 1.
- Full FIFO: push DEPTH entries with no pop (ALU saturating, STARVE_MAX not reached) -> mc_ready=0, fifo_count=4. The next mc_valid is not accepted, and the data is written later intact and in order.
